// File: rtl/btn_control_encoder.sv
// Button front end: sync, debounce and rise-detect four buttons, gather near-simultaneous
// presses into one chord word. Optional macro LONG_PRESS_CONFIRM_EN adds long-press confirm.
module btn_control_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CHORD_CYCLES    = 2500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] control,
  output logic       control_valid,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StCollect, StEmit, StWaitRelease} state_e;

  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ChordLast = CNT_W'(CHORD_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_dly_q;
  logic [3:0]       rise;
  logic [CNT_W-1:0] db_cnt_q [4];

  state_e           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] chord_cnt_q, chord_cnt_d;
  logic [3:0]       control_q, control_d;
  logic             valid_q, valid_d;

  // Sync + per-bit debounce: db only follows sync after DEBOUNCE_CYCLES of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign rise = db_q & ~db_dly_q;

`ifdef LONG_PRESS_CONFIRM_EN
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             long_done_q, long_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
    end
  end
`else
  logic unused_long_cycles;
  assign unused_long_cycles = ^LONG_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      chord_cnt_q <= '0;
      control_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      chord_cnt_q <= chord_cnt_d;
      control_q   <= control_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    chord_cnt_d = chord_cnt_q;
    control_d   = '0;
    valid_d     = 1'b0;
`ifdef LONG_PRESS_CONFIRM_EN
    long_cnt_d  = '0;
    long_done_d = long_done_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef LONG_PRESS_CONFIRM_EN
        long_done_d = 1'b0;
`endif
        if (rise != '0) begin
          mask_d      = rise;
          chord_cnt_d = '0;
          state_d     = StCollect;
        end
      end
      StCollect: begin
        // Releases inside the window never clear mask bits; a last-cycle rise still counts.
        mask_d      = mask_q | rise;
        chord_cnt_d = chord_cnt_q + CntOne;
        if (chord_cnt_q == ChordLast) begin
          control_d = mask_q | rise;
          valid_d   = 1'b1;
          state_d   = StEmit;
        end
      end
      StEmit: begin
        state_d = StWaitRelease;
      end
      StWaitRelease: begin
`ifdef LONG_PRESS_CONFIRM_EN
        if (db_q == '0) begin
          state_d = StIdle;
        end else begin
          long_cnt_d = long_cnt_q + CntOne;
          // A chord that was already a confirm does not get a second one.
          if (long_cnt_q == LongLast && !long_done_q && mask_q != 4'b1111) begin
            control_d   = 4'b1111;
            valid_d     = 1'b1;
            long_done_d = 1'b1;
          end
        end
`else
        if (db_q == '0) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign control       = control_q;
  assign control_valid = valid_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_btn_control_encoder.sv
// Directed bench for btn_control_encoder with short debounce/chord/long windows.
module tb_btn_control_encoder;

  localparam int unsigned DbC = 4;
  localparam int unsigned ChC = 8;
  localparam int unsigned LgC = 20;
`ifdef LONG_PRESS_CONFIRM_EN
  localparam int ExpLong = 1;
`else
  localparam int ExpLong = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] control;
  logic       control_valid;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  int         cyc, npulse, first_idx, second_idx, inv_err;
  logic [3:0] first_val, last_val;
  logic       prev_nz, busy_seen;

  btn_control_encoder #(
    .DEBOUNCE_CYCLES(DbC),
    .CHORD_CYCLES   (ChC),
    .LONG_CYCLES    (LgC),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .control      (control),
    .control_valid(control_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc        = -1;
    npulse     = 0;
    first_idx  = -1;
    second_idx = -1;
    inv_err    = 0;
    first_val  = 4'b0;
    last_val   = 4'b0;
    prev_nz    = 1'b0;
    busy_seen  = 1'b0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (control_valid !== (control != 4'b0)) inv_err++;
      if (control !== 4'b0) begin
        if (prev_nz) inv_err++;
        npulse++;
        if (npulse == 1) begin
          first_idx = cyc;
          first_val = control;
        end else if (npulse == 2) begin
          second_idx = cyc;
        end
        last_val = control;
      end
      prev_nz = (control !== 4'b0);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_control", control, 4'b0);
    check("rst_valid", control_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(5);

    // Single button: db rises after edge 5, word visible at cycle 14.
    clear_mon();
    btn_raw = 4'b1000;
    step(40);
    btn_raw = 4'b0000;
    step(30);
    check("t1_npulse", npulse, 1 + ExpLong);
    check("t1_val", first_val, 4'b1000);
    check("t1_idx", first_idx, 14);
    check("t1_busy_seen", busy_seen, 1'b1);
    check("t1_busy_end", busy, 1'b0);
    check("t1_inv", inv_err, 0);

    // Two-cycle glitch is filtered.
    clear_mon();
    btn_raw = 4'b0100;
    step(2);
    btn_raw = 4'b0000;
    step(20);
    check("t2_npulse", npulse, 0);
    check("t2_busy_seen", busy_seen, 1'b0);

    // Staggered presses inside the window form one confirm; no long confirm after it.
    clear_mon();
    btn_raw = 4'b1000;
    step(3);
    btn_raw = 4'b1100;
    step(3);
    btn_raw = 4'b1111;
    step(30);
    btn_raw = 4'b0000;
    step(30);
    check("t3_npulse", npulse, 1);
    check("t3_val", first_val, 4'b1111);
    check("t3_idx", first_idx, 14);
    check("t3_inv", inv_err, 0);

    // Release inside the window keeps the bit; a later press is merged.
    clear_mon();
    btn_raw = 4'b1000;
    step(5);
    btn_raw = 4'b0000;
    step(1);
    btn_raw = 4'b0100;
    step(10);
    btn_raw = 4'b0000;
    step(30);
    check("t4_npulse", npulse, 1);
    check("t4_val", first_val, 4'b1100);
    check("t4_busy_end", busy, 1'b0);

    // Reset during COLLECT aborts; held button then counts as a fresh press.
    clear_mon();
    btn_raw = 4'b1000;
    step(9);
    check("t5_busy_collect", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_control", control, 4'b0);
    check("t5_rst_valid", control_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    step(3);
    check("t5_npulse_pre", npulse, 0);
    clear_mon();
    rst_n = 1'b1;
    step(16);
    btn_raw = 4'b0000;
    step(30);
    check("t5_npulse", npulse, 1);
    check("t5_val", first_val, 4'b1000);
    check("t5_idx", first_idx, 14);
    check("t5_inv", inv_err, 0);

    // Long hold: chord word, then a long confirm only when the feature is built in.
    clear_mon();
    btn_raw = 4'b1000;
    step(60);
    btn_raw = 4'b0000;
    step(30);
    check("t6_npulse", npulse, 1 + ExpLong);
    check("t6_val", first_val, 4'b1000);
    check("t6_idx", first_idx, 14);
    check("t6_last_val", last_val, (ExpLong != 0) ? 4'b1111 : 4'b1000);
`ifdef LONG_PRESS_CONFIRM_EN
    check("t6_long_idx", second_idx, 35);
`endif
    check("t6_inv", inv_err, 0);
    check("t6_busy_end", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
